// File: rtl/button_debouncer.sv
// Push-button conditioner: a synchronizer, then a debounce FSM.
// Produces a debounced level, 1-cycle press/release strobes and a wrapping press counter.
// Every output is a register, so there is no combinational path from button to any output.
module button_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 button,
  output logic                 btn_level,
  output logic                 btn_press,
  output logic                 btn_release,
  output logic [CNT_WIDTH-1:0] press_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DB_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  // FSM state is kept in state_q so checkers can bind to it directly.
  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_s;
  logic [DW-1:0]          cnt_q, cnt_d;
  logic                   level_d, press_d, release_d;
  logic [CNT_WIDTH-1:0]   count_d;

  assign btn_s = sync_q[SYNC_STAGES-1];

  // Synchronizer shift chain for the asynchronous button pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], button};
  end

  // State, debounce counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE_LOW;
      cnt_q       <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      press_count <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      btn_level   <= level_d;
      btn_press   <= press_d;
      btn_release <= release_d;
      press_count <= count_d;
    end
  end

  // Next-state logic. The counter holds the number of consecutive cycles btn_s
  // has disagreed with the accepted level; it clears whenever they agree.
  // A change is accepted on the cycle the counter has already reached DB_LAST.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = btn_level;
    press_d   = 1'b0;
    release_d = 1'b0;
    count_d   = press_count;
    case (state_q)
      IDLE_LOW: begin
        cnt_d = '0;
        if (btn_s) begin
          state_d = WAIT_HIGH;
          cnt_d   = DW'(1);
        end
      end
      WAIT_HIGH: begin
        if (!btn_s) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
          count_d = press_count + CNT_WIDTH'(1);
        end else if (cnt_q != DB_MAX) begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      IDLE_HIGH: begin
        cnt_d = '0;
        if (!btn_s) begin
          state_d = WAIT_LOW;
          cnt_d   = DW'(1);
        end
      end
      WAIT_LOW: begin
        if (btn_s) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d   = IDLE_LOW;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else if (cnt_q != DB_MAX) begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Testbench for button_debouncer (DEBOUNCE_CYCLES=16, SYNC_STAGES=2, CNT_WIDTH=3).
// Scenario tasks drive the button and push expected strobes {is_press, press_count}
// with their expected cycle; a negedge monitor pops and compares every strobe.
module tb_button_debouncer;

  localparam int DB  = 16;
  localparam int SS  = 2;
  localparam int CW  = 3;
  localparam int LAT = SS + DB;
  localparam int W   = CW + 1;

  logic          clk;
  logic          rst_n;
  logic          button;
  logic          btn_level;
  logic          btn_press;
  logic          btn_release;
  logic [CW-1:0] press_count;

  logic [W-1:0]  exp_q[$];
  int            exp_t_q[$];
  logic [CW-1:0] model_count;
  int            cyc;
  int            checks;
  int            failures;

  button_debouncer #(
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DB),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .button     (button),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .press_count(press_count)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the head of the expected queue in kind,
  // count, level and timing (+/-1 cycle).
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] e;
    int           t;
    if (btn_press && btn_release) begin
      checks++;
      failures++;
      $display("FAIL both_strobes cyc=%0d press=1 release=1 required=not both", cyc);
    end
    if (btn_press || btn_release) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe cyc=%0d press=%0b release=%0b count=%0d required=no strobe",
                 cyc, btn_press, btn_release, press_count);
      end else begin
        got = {btn_press, press_count};
        e   = exp_q.pop_front();
        t   = exp_t_q.pop_front();
        if (got !== e || btn_level !== e[W-1]) begin
          failures++;
          $display("FAIL strobe_value cyc=%0d got press=%0b count=%0d level=%0b required press=%0b count=%0d level=%0b",
                   cyc, got[W-1], got[CW-1:0], btn_level, e[W-1], e[CW-1:0], e[W-1]);
        end
        checks++;
        if (cyc < t - 1 || cyc > t + 1) begin
          failures++;
          $display("FAIL strobe_time got cyc=%0d required cyc=%0d (+/-1)", cyc, t);
        end
      end
    end
  end

  // Driver: set button at a negedge, optionally expect an accepted change, hold.
  task automatic drive(input logic v, input int hold_cycles, input bit accept);
    @(negedge clk);
    button = v;
    if (accept) begin
      if (v) begin
        model_count = model_count + 1'b1;
        exp_q.push_back({1'b1, model_count});
      end else begin
        exp_q.push_back({1'b0, model_count});
      end
      exp_t_q.push_back(cyc + LAT);
    end
    repeat (hold_cycles - 1) @(negedge clk);
  endtask

  task automatic apply_reset(input logic btn_val);
    @(negedge clk);
    rst_n  = 1'b0;
    button = btn_val;
    model_count = '0;
    exp_q.delete();
    exp_t_q.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic drain_check(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_missing_strobes got pending=%0d required=0", name, exp_q.size());
      exp_q.delete();
      exp_t_q.delete();
    end
  endtask

  task automatic test_reset();
    apply_reset(1'b1);
    checks++;
    if ({btn_level, btn_press, btn_release, press_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got level=%0b press=%0b release=%0b count=%0d required all 0",
               btn_level, btn_press, btn_release, press_count);
    end
    rst_n = 1'b1;
    model_count = 3'd1;
    exp_q.push_back({1'b1, 3'd1});
    exp_t_q.push_back(cyc + LAT);
    repeat (30) @(negedge clk);
    checks++;
    if (btn_level !== 1'b1 || press_count !== 3'd1) begin
      failures++;
      $display("FAIL reset_first_press got level=%0b count=%0d required level=1 count=1",
               btn_level, press_count);
    end
    drain_check("reset");
  endtask

  task automatic test_clean_press();
    drive(1'b0, 40, 1'b1);
    checks++;
    if (btn_level !== 1'b0) begin
      failures++;
      $display("FAIL clean_release_level got %0b required 0", btn_level);
    end
    drive(1'b1, 40, 1'b1);
    checks++;
    if (btn_level !== 1'b1 || press_count !== model_count) begin
      failures++;
      $display("FAIL clean_press got level=%0b count=%0d required level=1 count=%0d",
               btn_level, press_count, model_count);
    end
    drive(1'b0, 40, 1'b1);
    drain_check("clean");
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 20; i++) drive((i % 2) == 0, 3, 1'b0);
    checks++;
    if (btn_level !== 1'b0) begin
      failures++;
      $display("FAIL bounce_level got %0b required 0", btn_level);
    end
    drive(1'b1, 40, 1'b1);
    checks++;
    if (btn_level !== 1'b1 || press_count !== model_count) begin
      failures++;
      $display("FAIL bounce_settle got level=%0b count=%0d required level=1 count=%0d",
               btn_level, press_count, model_count);
    end
    drive(1'b0, 40, 1'b1);
    drain_check("bounce");
  endtask

  task automatic test_glitch();
    drive(1'b1, DB - 1, 1'b0);
    drive(1'b0, 40, 1'b0);
    checks++;
    if (btn_level !== 1'b0 || press_count !== model_count) begin
      failures++;
      $display("FAIL glitch got level=%0b count=%0d required level=0 count=%0d",
               btn_level, press_count, model_count);
    end
    drain_check("glitch");
  endtask

  task automatic test_wrap();
    apply_reset(1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 30, 1'b1);
      checks++;
      if (press_count !== model_count) begin
        failures++;
        $display("FAIL wrap_count press=%0d got %0d required %0d", i + 1, press_count, model_count);
      end
      drive(1'b0, 30, 1'b1);
    end
    checks++;
    if (press_count !== 3'd1) begin
      failures++;
      $display("FAIL wrap_final got %0d required 1", press_count);
    end
    drain_check("wrap");
  endtask

  task automatic test_reset_mid_wait();
    // Button rises at negedge c; counter reads 10 after edge c+12.
    drive(1'b1, 12, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({btn_level, btn_press, btn_release, press_count} !== '0) begin
      failures++;
      $display("FAIL midwait_reset got level=%0b press=%0b release=%0b count=%0d required all 0",
               btn_level, btn_press, btn_release, press_count);
    end
    model_count = '0;
    exp_q.delete();
    exp_t_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_count = 3'd1;
    exp_q.push_back({1'b1, 3'd1});
    exp_t_q.push_back(cyc + LAT);
    repeat (30) @(negedge clk);
    checks++;
    if (btn_level !== 1'b1 || press_count !== 3'd1) begin
      failures++;
      $display("FAIL midwait_requalify got level=%0b count=%0d required level=1 count=1",
               btn_level, press_count);
    end
    drive(1'b0, 40, 1'b1);
    drain_check("midwait");
  endtask

  // Watchdog bound on the whole run
  initial begin
    #1000000;
    $display("FAIL watchdog_timeout cyc=%0d required finish", cyc);
    $fatal(1, "timeout");
  end

  // Main sequence and final report
  initial begin
    checks      = 0;
    failures    = 0;
    model_count = '0;
    rst_n       = 1'b0;
    button      = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_wrap();
    test_reset_mid_wait();
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
